// File: rtl/i2c_slave_byte_ctrl_if.sv
// Register-side and pad-side signal bundle of the I2C responder byte engine.
interface i2c_slave_byte_ctrl_if;
  logic       Scl_i;
  logic       Sda_i;
  logic       Sda_oe;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic       Rx_nack;
  logic [7:0] Tx_data;
  logic       Tx_req;
  logic       Rw;
  logic       Busy;

  // Responder (design) side
  modport slave (
    input  Scl_i, Sda_i, Rx_nack, Tx_data,
    output Sda_oe, Rx_data, Rx_valid, Tx_req, Rw, Busy
  );

  // Bus master / register client side
  modport master (
    output Scl_i, Sda_i, Rx_nack, Tx_data,
    input  Sda_oe, Rx_data, Rx_valid, Tx_req, Rw, Busy
  );
endinterface

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C responder byte engine: START/STOP detection, 7-bit address match,
// per-byte ACK/NACK, receive to register port and transmit from register port.
// SCL is never driven; SDA is open-drain through Sda_oe.
module i2c_slave_byte_ctrl #(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned SIZE     = 3
) (
  input  logic Clk,
  input  logic Rst_n,
  i2c_slave_byte_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  localparam logic [SIZE-1:0] CNT_LOAD = SIZE'(7);

  state_t          state;
  logic [SIZE-1:0] cnt;
  logic [6:0]      shifter;
  logic            bit8;
  logic            nack_q;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  logic       scl_rise, scl_fall, start_det, stop_det, addr_hit;
  logic [7:0] shift_in;

  // Two-flop synchroniser plus one delay flop per bus line
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= bus.Scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= bus.Sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  // Bus events and the byte being assembled from the current SDA sample
  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    shift_in  = {shifter, sda_s2};
    addr_hit  = (shift_in[7:1] == SLV_ADDR) && (shift_in[7:1] != 7'h00);
  end

  // Byte/ACK sequencer with registered bus and register-port outputs.
  // Busy doubles as the address-matched flag inside ADDR.
  // In TX the shifter holds only the bits not yet on the bus; bit7 is
  // driven straight from Tx_data when the byte is loaded.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      cnt          <= CNT_LOAD;
      shifter      <= '0;
      bit8         <= 1'b0;
      nack_q       <= 1'b0;
      bus.Sda_oe   <= 1'b0;
      bus.Rx_data  <= '0;
      bus.Rx_valid <= 1'b0;
      bus.Tx_req   <= 1'b0;
      bus.Rw       <= 1'b0;
      bus.Busy     <= 1'b0;
    end else begin
      bus.Rx_valid <= 1'b0;
      bus.Tx_req   <= 1'b0;
      if (stop_det) begin
        state      <= IDLE;
        bus.Busy   <= 1'b0;
        bus.Sda_oe <= 1'b0;
        bit8       <= 1'b0;
      end else if (start_det) begin
        state      <= ADDR;
        bus.Busy   <= 1'b0;
        bus.Sda_oe <= 1'b0;
        cnt        <= CNT_LOAD;
        bit8       <= 1'b0;
      end else begin
        case (state)
          IDLE: bus.Sda_oe <= 1'b0;

          ADDR: begin
            if (scl_rise) begin
              shifter <= shift_in[6:0];
              if (cnt == '0) begin
                cnt  <= CNT_LOAD;
                bit8 <= 1'b1;
                if (addr_hit) begin
                  bus.Rw   <= sda_s2;
                  bus.Busy <= 1'b1;
                end
              end else begin
                cnt <= cnt - 1'b1;
              end
            end else if (scl_fall && bit8) begin
              bit8 <= 1'b0;
              if (bus.Busy) begin
                bus.Sda_oe <= 1'b1;
                state      <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_rise) begin
              bus.Tx_req <= bus.Rw;
            end else if (scl_fall) begin
              cnt <= CNT_LOAD;
              if (bus.Rw) begin
                shifter    <= bus.Tx_data[6:0];
                bus.Sda_oe <= ~bus.Tx_data[7];
                state      <= TX;
              end else begin
                bus.Sda_oe <= 1'b0;
                state      <= RX;
              end
            end
          end

          RX: begin
            if (scl_rise) begin
              shifter <= shift_in[6:0];
              if (cnt == '0) begin
                cnt          <= CNT_LOAD;
                bit8         <= 1'b1;
                bus.Rx_data  <= shift_in;
                bus.Rx_valid <= 1'b1;
                nack_q       <= bus.Rx_nack;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end else if (scl_fall && bit8) begin
              bit8       <= 1'b0;
              bus.Sda_oe <= ~nack_q;
              state      <= RX_ACK;
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              bus.Sda_oe <= 1'b0;
              state      <= nack_q ? WAIT_STOP : RX;
            end
          end

          TX: begin
            if (scl_rise) begin
              if (cnt == '0) begin
                cnt  <= CNT_LOAD;
                bit8 <= 1'b1;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end else if (scl_fall) begin
              if (bit8) begin
                bit8       <= 1'b0;
                bus.Sda_oe <= 1'b0;
                state      <= TX_ACK;
              end else begin
                bus.Sda_oe <= ~shifter[6];
                shifter    <= {shifter[5:0], 1'b0};
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) bus.Tx_req <= 1'b1;
              else         state      <= WAIT_STOP;
            end else if (scl_fall) begin
              cnt        <= CNT_LOAD;
              shifter    <= bus.Tx_data[6:0];
              bus.Sda_oe <= ~bus.Tx_data[7];
              state      <= TX;
            end
          end

          WAIT_STOP: bus.Sda_oe <= 1'b0;

          default: begin
            bus.Sda_oe <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for the I2C responder: a timed bus master plus a transaction-level
// model of which bytes get ACKed, received and transmitted.
module tb_i2c_slave_byte_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  int rxv_cnt = 0, txr_cnt = 0, ovl_cnt = 0, oe_cnt = 0;

  logic [7:0] xd [4];
  logic       xn [4];

  i2c_slave_byte_ctrl_if bus_if ();

  assign bus_if.Scl_i = scl;
  assign bus_if.Sda_i = sda_m & ~bus_if.Sda_oe;

  i2c_slave_byte_ctrl #(.SLV_ADDR(7'h50), .SIZE(3)) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Pulse/drive activity counters
  always @(posedge clk) begin
    if (bus_if.Rx_valid) rxv_cnt++;
    if (bus_if.Tx_req) txr_cnt++;
    if (bus_if.Rx_valid && bus_if.Tx_req) ovl_cnt++;
    if (bus_if.Sda_oe) oe_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl) begin
      sda_m = 1'b1; wclk(4); sda_m = 1'b0; wclk(8); scl = 1'b0;
    end else begin
      wclk(4); sda_m = 1'b1; wclk(4); scl = 1'b1; wclk(6);
      sda_m = 1'b0; wclk(8); scl = 1'b0;
    end
  endtask

  task automatic bus_stop();
    wclk(4); sda_m = 1'b0; wclk(4); scl = 1'b1; wclk(6); sda_m = 1'b1; wclk(8);
  endtask

  task automatic slot(input logic drv, output logic seen);
    wclk(4); sda_m = drv; wclk(4); scl = 1'b1; wclk(6);
    seen = bus_if.Sda_i; wclk(2); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic sda9);
    logic s;
    for (int i = 7; i >= 0; i--) slot(b[i], s);
    slot(1'b1, sda9);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mnack, input logic [7:0] next_tx);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      slot(1'b1, s);
      b = {b[6:0], s};
    end
    bus_if.Tx_data = next_tx;
    slot(mnack, s);
  endtask

  // One transaction: START (or repeated START), address byte, n data bytes
  // from xd/xn, optional STOP. Expectations come from the addressing and
  // ACK rules only.
  task automatic xfer(input logic [6:0] a, input logic r, input int n, input logic with_stop);
    logic hit, alive, sda9;
    logic [7:0] got, exp_last;
    int rx0, tx0, oe0, exp_rx, exp_tx;
    hit = (a == 7'h50);
    exp_rx = 0;
    exp_tx = (hit && r) ? 1 : 0;
    exp_last = '0;
    rx0 = rxv_cnt; tx0 = txr_cnt;
    bus_if.Tx_data = xd[0];
    bus_start();
    oe0 = oe_cnt;
    check_eq("busy_after_start", {31'd0, bus_if.Busy}, 0);
    send_byte({a, r}, sda9);
    check_eq("addr_ack_sda", {31'd0, sda9}, {31'd0, !hit});
    check_eq("busy_after_addr", {31'd0, bus_if.Busy}, {31'd0, hit});
    if (hit) check_eq("rw", {31'd0, bus_if.Rw}, {31'd0, r});
    alive = hit;
    for (int i = 0; i < n; i++) begin
      if (!r) begin
        bus_if.Rx_nack = xn[i];
        send_byte(xd[i], sda9);
        check_eq("wr_ack_sda", {31'd0, sda9}, {31'd0, !(alive && !xn[i])});
        if (alive) begin
          exp_rx++;
          exp_last = xd[i];
        end
      end else begin
        recv_byte(got, xn[i], (i + 1 < n) ? xd[i + 1] : 8'h00);
        check_eq("rd_byte", {24'd0, got}, {24'd0, alive ? xd[i] : 8'hFF});
        if (alive && !xn[i]) exp_tx++;
      end
      alive = alive && !xn[i];
    end
    bus_if.Rx_nack = 1'b0;
    if (with_stop) begin
      bus_stop();
      check_eq("busy_after_stop", {31'd0, bus_if.Busy}, 0);
      check_eq("oe_after_stop", {31'd0, bus_if.Sda_oe}, 0);
    end
    check_eq("rx_valid_count", rxv_cnt - rx0, exp_rx);
    check_eq("tx_req_count", txr_cnt - tx0, exp_tx);
    if (exp_rx > 0) check_eq("rx_data", {24'd0, bus_if.Rx_data}, {24'd0, exp_last});
    if (!hit) check_eq("oe_idle_mismatch", oe_cnt - oe0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_oe"}, {31'd0, bus_if.Sda_oe}, 0);
    check_eq({tag, "_rxdata"}, {24'd0, bus_if.Rx_data}, 0);
    check_eq({tag, "_rxvalid"}, {31'd0, bus_if.Rx_valid}, 0);
    check_eq({tag, "_txreq"}, {31'd0, bus_if.Tx_req}, 0);
    check_eq({tag, "_rw"}, {31'd0, bus_if.Rw}, 0);
    check_eq({tag, "_busy"}, {31'd0, bus_if.Busy}, 0);
  endtask

  initial begin
    logic s;
    logic r;
    int n;
    logic [6:0] a;
    bus_if.Rx_nack = 1'b0;
    bus_if.Tx_data = '0;
    wclk(4);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wclk(8);

    // Write 0x3C to own address
    xd[0] = 8'h3C; xn[0] = 1'b0;
    xfer(7'h50, 1'b0, 1, 1'b1);

    // Foreign address: no ACK, nothing received
    xd[0] = 8'h3C; xd[1] = 8'h81; xn[0] = 1'b0; xn[1] = 1'b0;
    xfer(7'h51, 1'b0, 2, 1'b1);

    // Read 0xC5 twice, master ACK then NACK
    xd[0] = 8'hC5; xd[1] = 8'hC5; xn[0] = 1'b0; xn[1] = 1'b1;
    xfer(7'h50, 1'b1, 2, 1'b1);

    // Write with NACK on the second byte; third byte must also be refused
    xd[0] = 8'h11; xd[1] = 8'h96; xd[2] = 8'h77;
    xn[0] = 1'b0; xn[1] = 1'b1; xn[2] = 1'b0;
    xfer(7'h50, 1'b0, 3, 1'b1);

    // Address-only write, then repeated START into a read
    xfer(7'h50, 1'b0, 0, 1'b0);
    xd[0] = 8'h6B; xn[0] = 1'b1;
    xfer(7'h50, 1'b1, 1, 1'b1);

    // Reset while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'hA0;
      slot(ab[i], s);
    end
    wclk(4); sda_m = 1'b1; wclk(2);
    check_eq("ack_driven", {31'd0, bus_if.Sda_oe}, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    scl = 1'b1; sda_m = 1'b1;
    wclk(6);
    rst_n = 1'b1;
    wclk(6);
    xd[0] = 8'hE4; xn[0] = 1'b0;
    xfer(7'h50, 1'b0, 1, 1'b1);

    // Randomized transactions
    for (int k = 0; k < 16; k++) begin
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h50;
      r = 1'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        xd[i] = 8'($urandom);
        xn[i] = ($urandom_range(0, 3) == 0);
      end
      if (r) xn[n - 1] = 1'b1;
      xfer(a, r, n, (k == 15) || ($urandom_range(0, 3) != 0));
    end

    check_eq("rxvalid_txreq_overlap", ovl_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
